coin_pulse_ctrl: RTL and testbench



---
 rtl/coin_pulse_ctrl.sv | 166 ++++++++++++++++
 tb/tb_coin_pulse_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/coin_pulse_ctrl.sv
// Frame-paced coin conditioner: samples coin buttons once per video frame, queues
// accepted coins and replays them to the core as fixed-width pulses with gaps.
module coin_pulse_ctrl #(
    parameter int PULSE_FRAMES = 3,
    parameter int GAP_FRAMES   = 3
) (
    input  logic       MCLK,
    input  logic       RESET_N,
    input  logic       VBLK,
    input  logic       COIN1,
    input  logic       COIN2,
    output logic       COIN,
    output logic [2:0] PENDING,
    output logic [7:0] COIN_CNT,
    output logic       DROP
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_FRAMES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_FRAMES - 1);

    logic vblk_meta, vblk_sync, vblk_prev, tick;
    logic coin1_meta, coin1_sync, coin1_prev;
    logic coin2_meta, coin2_sync, coin2_prev;

    state_t     state;
    logic [3:0] fcnt;

    logic       press1, press2;
    logic [1:0] inc;
    logic       take;
    logic [3:0] sum;
    logic [2:0] pending_next;
    logic [1:0] dropped;
    logic [1:0] accepted;

    // VBLK resets high so a blank held across reset release never fakes a frame tick.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            vblk_meta  <= 1'b1;
            vblk_sync  <= 1'b1;
            vblk_prev  <= 1'b1;
            tick       <= 1'b0;
            coin1_meta <= 1'b0;
            coin1_sync <= 1'b0;
            coin2_meta <= 1'b0;
            coin2_sync <= 1'b0;
        end else begin
            vblk_meta  <= VBLK;
            vblk_sync  <= vblk_meta;
            vblk_prev  <= vblk_sync;
            tick       <= vblk_sync & ~vblk_prev;
            coin1_meta <= COIN1;
            coin1_sync <= coin1_meta;
            coin2_meta <= COIN2;
            coin2_sync <= coin2_meta;
        end
    end

    // Previous frame samples reset to 1 so a button held through reset needs a fresh press.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            coin1_prev <= 1'b1;
            coin2_prev <= 1'b1;
        end else if (tick) begin
            coin1_prev <= coin1_sync;
            coin2_prev <= coin2_sync;
        end
    end

    assign press1 = tick & coin1_sync & ~coin1_prev;
    assign press2 = tick & coin2_sync & ~coin2_prev;
    assign inc    = {1'b0, press1} + {1'b0, press2};

    // The queue take looks at PENDING before this tick's presses are added.
    always_comb begin
        take = 1'b0;
        if (tick) begin
            case (state)
                IDLE:    take = (PENDING != 3'd0);
                GAP:     take = (fcnt == 4'd0) && (PENDING != 3'd0);
                default: take = 1'b0;
            endcase
        end
    end

    always_comb begin
        sum          = {1'b0, PENDING} + {2'b00, inc} - {3'b000, take};
        pending_next = sum[2:0];
        dropped      = 2'd0;
        if (sum > 4'd7) begin
            pending_next = 3'd7;
            dropped      = 2'(sum - 4'd7);
        end
        accepted = inc - dropped;
    end

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            PENDING  <= 3'd0;
            COIN_CNT <= 8'd0;
            DROP     <= 1'b0;
        end else begin
            PENDING  <= pending_next;
            COIN_CNT <= COIN_CNT + {6'd0, accepted};
            if (dropped != 2'd0)
                DROP <= 1'b1;
        end
    end

    // Pulse/gap sequencer; every legal transition waits for a frame tick.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            fcnt  <= 4'd0;
            COIN  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state <= PULSE;
                        fcnt  <= PULSE_LOAD;
                        COIN  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (tick) begin
                        if (fcnt == 4'd0) begin
                            state <= GAP;
                            fcnt  <= GAP_LOAD;
                            COIN  <= 1'b0;
                        end else begin
                            fcnt <= fcnt - 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (fcnt == 4'd0) begin
                            if (take) begin
                                state <= PULSE;
                                fcnt  <= PULSE_LOAD;
                                COIN  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            fcnt <= fcnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    fcnt  <= 4'd0;
                    COIN  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_pulse_ctrl.sv
// Directed bench for coin_pulse_ctrl: one frame per applyStimulus call, outputs
// compared against hand-derived per-frame expectations.
module tb_coin_pulse_ctrl;

    logic       MCLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       VBLK = 1'b1;
    logic       COIN1 = 1'b0;
    logic       COIN2 = 1'b0;
    logic       COIN;
    logic [2:0] PENDING;
    logic [7:0] COIN_CNT;
    logic       DROP;

    int checkCount = 0;
    int passCount  = 0;

    coin_pulse_ctrl #(.PULSE_FRAMES(3), .GAP_FRAMES(3)) dut (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .VBLK    (VBLK),
        .COIN1   (COIN1),
        .COIN2   (COIN2),
        .COIN    (COIN),
        .PENDING (PENDING),
        .COIN_CNT(COIN_CNT),
        .DROP    (DROP)
    );

    always #5 MCLK = ~MCLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected)
            passCount++;
        else
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // One video frame: blank low then high; the tick lands inside the high phase.
    task automatic applyStimulus(input logic c1, input logic c2);
        COIN1 = c1;
        COIN2 = c2;
        VBLK  = 1'b0;
        repeat (5) @(posedge MCLK);
        #1 VBLK = 1'b1;
        repeat (5) @(posedge MCLK);
        #1;
    endtask

    task automatic holdReset(input int cycles);
        @(posedge MCLK);
        #1 RESET_N = 1'b0;
        VBLK = 1'b1;
        repeat (cycles) @(posedge MCLK);
        #1 RESET_N = 1'b1;
    endtask

    int t1Btn [9]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    int t1Coin[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    int t1Pend[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    int t2Coin[13] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    int t2Pend[13] = '{2, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int t3Coin[9]  = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
    int t3Pend[9]  = '{2, 1, 3, 3, 5, 5, 7, 6, 7};
    int t4Coin[7]  = '{1, 1, 1, 0, 0, 0, 0};

    initial begin
        int prevCoin;
        int expectRise;
        int riseCount;

        holdReset(4);
        checkOutput("reset_coin", COIN, 0);
        checkOutput("reset_pending", PENDING, 0);
        checkOutput("reset_cnt", COIN_CNT, 0);
        checkOutput("reset_drop", DROP, 0);
        repeat (10) @(posedge MCLK);
        #1 checkOutput("reset_vblk_high_no_change", PENDING, 0);

        $display("[TB] single press");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(t1Btn[i] != 0, 1'b0);
            checkOutput($sformatf("single_coin_f%0d", i + 1), COIN, t1Coin[i]);
            checkOutput($sformatf("single_pend_f%0d", i + 1), PENDING, t1Pend[i]);
        end
        checkOutput("single_cnt", COIN_CNT, 1);

        $display("[TB] simultaneous press");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(i == 0, i == 0);
            checkOutput($sformatf("simul_coin_f%0d", i), COIN, t2Coin[i]);
            checkOutput($sformatf("simul_pend_f%0d", i), PENDING, t2Pend[i]);
        end
        checkOutput("simul_cnt", COIN_CNT, 3);

        $display("[TB] saturation");
        for (int t = 1; t <= 9; t++) begin
            applyStimulus((t % 2) == 1, (t % 2) == 1);
            checkOutput($sformatf("sat_coin_t%0d", t), COIN, t3Coin[t - 1]);
            checkOutput($sformatf("sat_pend_t%0d", t), PENDING, t3Pend[t - 1]);
            checkOutput($sformatf("sat_drop_t%0d", t), DROP, (t == 9) ? 1 : 0);
        end
        checkOutput("sat_cnt", COIN_CNT, 12);
        prevCoin   = COIN;
        expectRise = 14;
        riseCount  = 0;
        for (int t = 10; t <= 56; t++) begin
            applyStimulus(1'b0, 1'b0);
            if (COIN == 1'b1 && prevCoin == 0) begin
                checkOutput("sat_rise_frame", t, expectRise);
                expectRise += 6;
                riseCount++;
            end
            prevCoin = COIN;
            if (t == 14)
                checkOutput("sat_pend_t14", PENDING, 6);
        end
        checkOutput("sat_rise_count", riseCount, 7);
        checkOutput("sat_final_pend", PENDING, 0);
        checkOutput("sat_final_coin", COIN, 0);
        checkOutput("sat_final_cnt", COIN_CNT, 12);
        checkOutput("sat_drop_sticky", DROP, 1);

        $display("[TB] held through reset");
        COIN1 = 1'b1;
        holdReset(3);
        checkOutput("held_reset_drop", DROP, 0);
        checkOutput("held_reset_cnt", COIN_CNT, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("held_cnt_f%0d", i), COIN_CNT, 0);
            checkOutput($sformatf("held_coin_f%0d", i), COIN, 0);
        end
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("held_repress_pend", PENDING, 1);
        checkOutput("held_repress_cnt", COIN_CNT, 1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("held_pulse_f%0d", i), COIN, t4Coin[i]);
        end
        checkOutput("held_final_cnt", COIN_CNT, 1);

        $display("[TB] reset mid-pulse");
        applyStimulus(1'b1, 1'b1);
        checkOutput("mid_pend_a", PENDING, 2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("mid_coin_b", COIN, 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mid_coin_c", COIN, 1);
        checkOutput("mid_pend_c", PENDING, 3);
        checkOutput("mid_cnt_c", COIN_CNT, 5);
        COIN1 = 1'b0;
        COIN2 = 1'b0;
        RESET_N = 1'b0;
        @(posedge MCLK);
        #1;
        checkOutput("mid_rst_coin", COIN, 0);
        checkOutput("mid_rst_pend", PENDING, 0);
        checkOutput("mid_rst_cnt", COIN_CNT, 0);
        checkOutput("mid_rst_drop", DROP, 0);
        repeat (3) @(posedge MCLK);
        #1 RESET_N = 1'b1;
        repeat (10) @(posedge MCLK);
        #1;
        checkOutput("mid_release_coin", COIN, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("mid_no_spurious_tick_cnt", COIN_CNT, 0);
        checkOutput("mid_no_spurious_tick_pend", PENDING, 0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] counter wrap");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 1'b0);
            repeat (5) applyStimulus(1'b0, 1'b0);
            if (i == 254)
                checkOutput("wrap_cnt_255", COIN_CNT, 255);
        end
        checkOutput("wrap_cnt_0", COIN_CNT, 0);
        checkOutput("wrap_drop", DROP, 0);
        checkOutput("wrap_pend", PENDING, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
